// File: rtl/i3c2_cap_pkg.sv
// Shared types and constants for the OV7670 register capture bank.
package i3c2_cap_pkg;

    // Controller states: waiting, single read cycle, zeroing sweep
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_CLEAR = 2'd2
    } cap_state_e;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    // Write counter sticks here instead of wrapping
    localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/i3c2_cap_ram.sv
// Capture storage: one write port, one synchronous read-first read port.
module i3c2_cap_ram
    import i3c2_cap_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1 << AW];

    // Read returns the contents from before a same-edge write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/i3c2_reg_capture.sv
// Capture bank for bytes read back from the OV7670 by the I2C sequencer.
// Optional feature macro: I3C2_CHANGE_IRQ_EN (dirty vector and chg_irq).
// Entries whose valid bit is clear always read back as zero, so a sweep
// slot that loses the RAM write port to a capture still reads correctly.
module i3c2_reg_capture
    import i3c2_cap_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] DONE_ADDR = 5'd31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [15:0]       wr_count,
    output logic              done,
    output logic              chg_irq
);

    localparam int N_ENT = 1 << ADDR_W;

    cap_state_e        state_q;
    logic [ADDR_W-1:0] sweep_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic [N_ENT-1:0]  valid_q, valid_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              pend_fwd_q;
    logic [DATA_W-1:0] pend_data_q;
    logic              rd_ack_q, rd_valid_q, done_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              clr_start, accept, sweep_we, ram_we, rd_hit;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    // Request decode and RAM write-port arbitration (capture beats sweep)
    always_comb begin
        clr_start = clr && (state_q != ST_RD);
        accept    = (state_q == ST_IDLE) && !clr && rd_req;
        sweep_we  = (state_q == ST_CLEAR) && !wr_en && !valid_q[sweep_q];
        ram_we    = wr_en || sweep_we;
        ram_waddr = wr_en ? wr_addr : sweep_q;
        ram_wdata = wr_en ? wr_data : '0;
        rd_hit    = wr_en && (wr_addr == rd_idx_q);
    end

    i3c2_cap_ram #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // Valid bits and write counter: clear on sweep start, capture always lands
    always_comb begin
        valid_d    = valid_q;
        wr_count_d = wr_count_q;
        if (clr_start) begin
            valid_d    = '0;
            wr_count_d = '0;
        end
        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
            if (wr_count_d != WR_COUNT_MAX) begin
                wr_count_d = wr_count_d + 16'd1;
            end
        end
    end

    // Control FSM: sweep sequencing, read accept and acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            valid_q    <= '0;
            wr_count_q <= '0;
            rd_ack_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            wr_count_q <= wr_count_d;
            rd_ack_q   <= (state_q == ST_RD);
            done_q     <= wr_en && (wr_addr == DONE_ADDR);
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        sweep_q <= '0;
                    end else if (rd_req) begin
                        state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    state_q <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (clr) begin
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                        if (&sweep_q) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    sweep_q <= '0;
                end
            endcase
        end
    end

    // Latch read index, plus any capture to it on the accept edge (RAM is read-first)
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_idx_q    <= rd_addr;
            pend_fwd_q  <= wr_en && (wr_addr == rd_addr);
            pend_data_q <= wr_data;
        end
    end

    // Read result: newest capture wins, otherwise masked RAM contents
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (state_q == ST_RD) begin
            if (rd_hit) begin
                rd_data_q  <= wr_data;
                rd_valid_q <= 1'b1;
            end else if (pend_fwd_q) begin
                rd_data_q  <= pend_data_q;
                rd_valid_q <= 1'b1;
            end else begin
                rd_data_q  <= valid_q[rd_idx_q] ? ram_rdata : '0;
                rd_valid_q <= valid_q[rd_idx_q];
            end
        end
    end

`ifdef I3C2_CHANGE_IRQ_EN
    logic [N_ENT-1:0] dirty_q, dirty_d;
    logic             chg_irq_q;

    // Dirty tracking: acked read clears, capture sets and wins a tie
    always_comb begin
        dirty_d = dirty_q;
        if (clr_start) begin
            dirty_d = '0;
        end
        if (state_q == ST_RD) begin
            dirty_d[rd_idx_q] = 1'b0;
        end
        if (wr_en) begin
            dirty_d[wr_addr] = 1'b1;
        end
    end

    // Dirty vector and its registered OR
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_q   <= '0;
            chg_irq_q <= 1'b0;
        end else begin
            dirty_q   <= dirty_d;
            chg_irq_q <= |dirty_d;
        end
    end

    assign chg_irq = chg_irq_q;
`else
    assign chg_irq = 1'b0;
`endif

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == ST_CLEAR);
    assign wr_count = wr_count_q;
    assign done     = done_q;

endmodule

// File: tb/tb_i3c2_reg_capture.sv
// Randomized bench for i3c2_reg_capture against a transaction-level model.
module tb_i3c2_reg_capture;

    logic        clk = 1'b0;
    logic        rst, wr_en, clr, rd_req;
    logic [4:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic        rd_ack, rd_valid, busy, done, chg_irq;
    logic [7:0]  rd_data;
    logic [15:0] wr_count;

    i3c2_reg_capture dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr      (clr),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .wr_count (wr_count),
        .done     (done),
        .chg_irq  (chg_irq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int done_seen = 0;

    // Reference model: bank contents as the host should see them
    logic [7:0] m_mem [32];
    bit         m_val [32];
    bit         m_dirty [32];
    int         m_cnt, m_busy, m_idx;
    bit         m_pend;
    bit         e_ack, e_done, e_rv;
    logic [7:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_wipe();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 8'h00;
            m_val[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_cnt = 0;
        m_busy = 32;
    endtask

    task automatic model_edge();
        bit was_pend;
        int busy0;
        was_pend = m_pend;
        busy0 = m_busy;
        if (rst) begin
            model_wipe();
            m_pend = 0;
            e_ack = 0; e_done = 0; e_rv = 0; e_data = 8'h00;
            return;
        end
        e_ack = was_pend;
        e_done = 0;
        if (clr && !was_pend) model_wipe();
        else if (m_busy > 0) m_busy--;
        if (wr_en) begin
            m_mem[wr_addr] = wr_data;
            m_val[wr_addr] = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            e_done = (wr_addr == 5'd31);
        end
        if (was_pend) begin
            e_data = m_val[m_idx] ? m_mem[m_idx] : 8'h00;
            e_rv = m_val[m_idx];
            m_pend = 0;
            m_dirty[m_idx] = 1'b0;
        end
        if (wr_en) m_dirty[wr_addr] = 1'b1;
        if (!was_pend && busy0 == 0 && rd_req && !clr) begin
            m_pend = 1;
            m_idx = rd_addr;
        end
    endtask

    function automatic bit exp_irq();
        bit any;
        any = 0;
`ifdef I3C2_CHANGE_IRQ_EN
        for (int i = 0; i < 32; i++) any |= m_dirty[i];
`endif
        return any;
    endfunction

    task automatic cycle(input bit do_chk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (done) done_seen++;
        if (do_chk) begin
            chk("rd_ack", rd_ack, e_ack);
            chk("rd_data", rd_data, e_data);
            chk("rd_valid", rd_valid, e_rv);
            chk("busy", busy, m_busy > 0);
            chk("wr_count", wr_count, m_cnt);
            chk("done", done, e_done);
            chk("chg_irq", chg_irq, exp_irq());
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1; wr_addr = a[4:0]; wr_data = d[7:0];
        cycle(1);
        wr_en = 0;
    endtask

    task automatic do_read(input int idx, output int lat);
        lat = 0;
        rd_req = 1; rd_addr = idx[4:0];
        for (int k = 1; k <= 8; k++) begin
            cycle(1);
            if (rd_ack) begin
                lat = k;
                break;
            end
        end
        rd_req = 0;
        if (lat == 0) chk("rd_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy; k++) cycle(1);
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    task automatic pulse_clr();
        clr = 1;
        cycle(1);
        clr = 0;
    endtask

    initial begin
        int lat, n;
        bit hold, fell;
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
        clr = 0; rd_req = 0; rd_addr = 0;
        m_pend = 0;

        // reset state
        repeat (3) cycle(1);
        chk("rst_busy", busy, 1);
        chk("rst_ack", rd_ack, 0);
        rst = 0;
        n = 0; fell = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1);
            n++;
            if (!busy) begin
                fell = 1;
                break;
            end
        end
        chk("busy_len", fell ? n : 0, 32);

        do_read(5, lat);
        chk("rd5_lat", lat, 2);
        chk("rd5_data", rd_data, 8'h00);
        chk("rd5_valid", rd_valid, 0);

        wr(10, 8'h76);
        do_read(10, lat);
        chk("rd10_lat", lat, 2);
        chk("rd10_data", rd_data, 8'h76);
        chk("rd10_valid", rd_valid, 1);
        chk("cnt_one", wr_count, 1);

        // write collides with the read cycle of the same index
        wr(3, 8'h3C);
        rd_req = 1; rd_addr = 5'd3;
        cycle(1);
        rd_req = 0;
        wr_en = 1; wr_addr = 5'd3; wr_data = 8'hA5;
        cycle(1);
        wr_en = 0;
        chk("fwd_ack", rd_ack, 1);
        chk("fwd_data", rd_data, 8'hA5);
        chk("fwd_valid", rd_valid, 1);

        // fill, clear, capture index 31 while the sweep is at index 10
        for (int i = 0; i < 32; i++) wr(i, (i * 13 + 7) & 8'hFF);
        cycle(1);
        done_seen = 0;
        pulse_clr();
        repeat (10) cycle(1);
        wr(31, 8'h11);
        wait_idle();
        chk("clr_done_once", done_seen, 1);
        for (int i = 0; i < 32; i++) begin
            do_read(i, lat);
            chk("sweep_data", rd_data, (i == 31) ? 8'h11 : 8'h00);
            chk("sweep_valid", rd_valid, (i == 31));
        end

        // randomized traffic with a well-behaved host
        hold = 0;
        for (int k = 0; k < 1500; k++) begin
            wr_en = ($urandom % 3) == 0;
            wr_addr = 5'($urandom);
            wr_data = 8'($urandom);
            clr = ($urandom % 250) == 0;
            if (!hold) begin
                rd_req = ($urandom % 3) == 0;
                rd_addr = 5'($urandom);
            end
            cycle(1);
            hold = rd_req && !rd_ack;
        end
        wr_en = 0; clr = 0; rd_req = 0;
        cycle(1);
        wait_idle();

        // saturation of the write counter
        pulse_clr();
        wait_idle();
        wr_en = 1;
        for (int k = 0; k < 70000; k++) begin
            wr_addr = 5'($urandom);
            wr_data = 8'($urandom);
            cycle((k % 4096 == 0) || (m_cnt > 65530 && m_cnt < 65540));
        end
        wr_en = 0;
        cycle(1);
        chk("cnt_sat", wr_count, 16'hFFFF);

        // change interrupt
        pulse_clr();
        wait_idle();
        chk("irq_idle", chg_irq, 0);
        wr(2, 8'h5A);
        cycle(1);
`ifdef I3C2_CHANGE_IRQ_EN
        chk("irq_set", chg_irq, 1);
`else
        chk("irq_set", chg_irq, 0);
`endif
        do_read(2, lat);
        chk("irq_rd_data", rd_data, 8'h5A);
        cycle(1);
        chk("irq_clr", chg_irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
